vga_text_renderer: RTL
======================

Name: vga_text_renderer

Overview:
- Text-mode pixel source that sits directly upstream of the VGA timing controller.
- Takes the controller's current pixel coordinate and fetches the character code from an external character RAM, then the glyph row from an external font ROM. It returns 10-bit R/G/B to the controller's colour inputs after a fixed pipeline latency.
- Screen is 80x30 cells of 8x16 pixels over the 640x480 active area, with a blinking underline cursor.

Parameters:
- COLS, 80, character columns per row.
- ROWS, 30, character rows per screen.
- BLINK_FRAMES, 30, frames per cursor blink phase.
- FG_COLOR, 30'h3FF_FFFFF, foreground {R,G,B}, 10 bits each.
- BG_COLOR, 30'h0, background {R,G,B}, 10 bits each.

Ports:
- iClk_25  in  1  pixel clock, ~25 MHz.
- nRst  in  1  asynchronous active-low reset.
- iCurrX  in  10  current pixel X from the VGA controller.
- iCurrY  in  10  current pixel Y from the VGA controller.
- oCharAddr  out  12  character RAM address, row*COLS+col.
- iCharData  in  8  character code; valid 1 cycle after oCharAddr.
- oFontAddr  out  12  font ROM address {char[7:0], glyph_row[3:0]}.
- iFontData  in  8  glyph row bits; valid 1 cycle after oFontAddr; bit 7 is the leftmost pixel.
- iCursorEn  in  1  cursor enable.
- iCursorCol  in  7  cursor column.
- iCursorRow  in  5  cursor row.
- oRed  out  10  red pixel value.
- oGreen  out  10  green pixel value.
- oBlue  out  10  blue pixel value.

Behaviour:
- One clock domain: iClk_25. Reset: nRst is asynchronous and active-low. All registers clear immediately on nRst=0.
- Reset values:
  - oCharAddr=0, oFontAddr=0, oRed/oGreen/oBlue=0.
  - All pipeline active flags=0.
  - Frame counter=0, blink_on=1, frame-tick history register=0.
- Pipeline, with the coordinate sampled at edge E0:
  - E0: register col=X[9:3], row=Y[8:4], px=X[2:0], py=Y[3:0]. active=(X<640)&&(Y<480). cur_hit=iCursorEn&&col==iCursorCol&&row==iCursorRow.
  - E1: oCharAddr<=row*COLS+col. The multiply is 5x7 bits and must produce a 12-bit result without truncation; max is 2399.
  - E2: no logic; this cycle waits for the RAM read.
  - E3: oFontAddr<={iCharData, py}.
  - E4: no logic; this cycle waits for the ROM read.
  - E5: register the output pixel.
  - Colour rules at E5:
    - !active: output 0.
    - Cursor applies (cur_hit&&blink_on&&py>=14): output FG_COLOR.
    - Otherwise: output iFontData[7-px] ? FG_COLOR : BG_COLOR.
  - px, py, active and cur_hit are delayed alongside so they align at each stage.
- Latency: output colour is valid exactly 5 cycles after its coordinate is presented. Throughput is 1 pixel/clock, with no stalls and no backpressure. Upstream compensates for the 5-cycle lag.
- Cursor inputs are sampled at E0 only. A mid-frame change affects later pixels only.
- Out-of-range cells:
  - Coordinates with X>=640 or Y>=480 may still issue RAM/ROM addresses.
  - Addresses are clamped: col>=COLS or row>=ROWS forces oCharAddr=0.
  - The colour output is 0 regardless.
- Frame tick:
  - A tick occurs when (iCurrX==0&&iCurrY==0) this cycle and it was not true the previous cycle. This gives one tick per frame even if (0,0) is held.
  - On a tick, if counter==BLINK_FRAMES-1: counter<=0 and blink_on<=~blink_on. Otherwise counter increments.
  - The counter width is sized for BLINK_FRAMES.
- Reset mid-frame: outputs go to 0 at once. The first valid colour appears 5 cycles after nRst deasserts and coordinates resume. blink_on restarts at 1.

Test Plan:
- Reset, then drive X=0..7, Y=0 with iCharData=8'h41 and iFontData=8'b1000_0001:
  - oCharAddr=0 one cycle after the first coordinate.
  - oFontAddr=12'h410.
  - Colour 5 cycles after each coordinate is FG at px=0 and px=7 and BG at px=1..6.
- Drive X=639, Y=479: oCharAddr=29*80+79=2399 and oFontAddr low nibble=4'hF. Drive X=640, Y=0 or X=0, Y=480: colour output is 0 after 5 cycles.
- Cursor case:
  - Setup: iCursorEn=1, col=5, row=2, blink_on=1, iFontData=0.
  - Drive X=40..47, Y=46 and 47: FG output.
  - Drive Y=45: BG output.
  - With iCursorEn=0: BG output.
- Blink timing:
  - With BLINK_FRAMES=2, cycle (0,0) entry 4 times: blink_on toggles after ticks 2 and 4.
  - Holding (0,0) for 10 cycles counts as a single tick.
- Assert nRst=0 mid-line with FG pixels in flight: oRed/oGreen/oBlue=0 immediately, with no clock edge needed. After release, the first non-zero pixel appears exactly 5 cycles after its coordinate.
- Continuous scan of a full 800x525 frame against a reference model: every output pixel matches, with the 5-cycle alignment and no bubbles.

Source files
------------

// File: rtl/vga_text_renderer.sv
// vga_text_renderer: 80x30 text-mode pixel source feeding a 640x480 VGA timing controller.
// A coordinate goes in, and its RGB comes out five clocks later. The char RAM and font ROM reads happen inside the pipeline.
module vga_text_renderer #(
    parameter int          COLS         = 80,
    parameter int          ROWS         = 30,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [29:0] FG_COLOR     = 30'h3FFF_FFFF,
    parameter logic [29:0] BG_COLOR     = 30'h0
) (
    input  logic        iClk_25,
    input  logic        nRst,
    input  logic [9:0]  iCurrX,
    input  logic [9:0]  iCurrY,
    output logic [11:0] oCharAddr,
    input  logic [7:0]  iCharData,
    output logic [11:0] oFontAddr,
    input  logic [7:0]  iFontData,
    input  logic        iCursorEn,
    input  logic [6:0]  iCursorCol,
    input  logic [4:0]  iCursorRow,
    output logic [9:0]  oRed,
    output logic [9:0]  oGreen,
    output logic [9:0]  oBlue
);

    localparam int               CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [7:0]       COLS_LIM = 8'(COLS);
    localparam logic [5:0]       ROWS_LIM = 6'(ROWS);
    localparam logic [11:0]      COLS_12  = 12'(COLS);

    // Per-pixel attributes that travel down the pipeline beside the memory reads.
    typedef struct packed {
        logic [2:0] px;
        logic [3:0] py;
        logic       act;
        logic       hit;
    } pix_tag_t;

    logic [6:0]       col_s1_q, col_s1_d;
    logic [4:0]       row_s1_q, row_s1_d;
    pix_tag_t         tag_s1_q, tag_s1_d;
    pix_tag_t         tag_s2_q, tag_s2_d;
    pix_tag_t         tag_s3_q, tag_s3_d;
    pix_tag_t         tag_s4_q, tag_s4_d;
    pix_tag_t         tag_s5_q, tag_s5_d;
    logic [11:0]      char_addr_q, char_addr_d;
    logic [11:0]      font_addr_q, font_addr_d;
    logic [29:0]      rgb_q, rgb_d;
    logic             origin_q, origin_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_on_q, blink_on_d;

    logic             at_origin;
    logic             cell_in_range;
    logic             cursor_px;

    always_comb begin
        at_origin = (iCurrX == 10'd0) && (iCurrY == 10'd0);

        col_s1_d = iCurrX[9:3];
        row_s1_d = iCurrY[8:4];
        tag_s1_d = '{px:  iCurrX[2:0],
                     py:  iCurrY[3:0],
                     act: (iCurrX < 10'd640) && (iCurrY < 10'd480),
                     hit: iCursorEn && (iCurrX[9:3] == iCursorCol) && (iCurrY[8:4] == iCursorRow)};

        // Off-screen cells still fetch, but from a harmless address.
        cell_in_range = ({1'b0, col_s1_q} < COLS_LIM) && ({1'b0, row_s1_q} < ROWS_LIM);
        char_addr_d   = cell_in_range ? (12'(row_s1_q) * COLS_12 + 12'(col_s1_q)) : 12'd0;
        tag_s2_d      = tag_s1_q;

        tag_s3_d      = tag_s2_q;

        font_addr_d   = {iCharData, tag_s3_q.py};
        tag_s4_d      = tag_s3_q;

        tag_s5_d      = tag_s4_q;

        cursor_px = tag_s5_q.hit && blink_on_q && (tag_s5_q.py >= 4'd14);
        if (!tag_s5_q.act) begin
            rgb_d = 30'h0;
        end else if (cursor_px) begin
            rgb_d = FG_COLOR;
        end else if (iFontData[3'd7 - tag_s5_q.px]) begin
            rgb_d = FG_COLOR;
        end else begin
            rgb_d = BG_COLOR;
        end

        // Only the first cycle at (0,0) counts, so holding the origin yields one tick.
        origin_d    = at_origin;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (at_origin && !origin_q) begin
            if (blink_cnt_q == CNT_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge iClk_25 or negedge nRst) begin
        if (!nRst) begin
            col_s1_q    <= '0;
            row_s1_q    <= '0;
            tag_s1_q    <= '0;
            tag_s2_q    <= '0;
            tag_s3_q    <= '0;
            tag_s4_q    <= '0;
            tag_s5_q    <= '0;
            char_addr_q <= '0;
            font_addr_q <= '0;
            rgb_q       <= '0;
            origin_q    <= 1'b0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            col_s1_q    <= col_s1_d;
            row_s1_q    <= row_s1_d;
            tag_s1_q    <= tag_s1_d;
            tag_s2_q    <= tag_s2_d;
            tag_s3_q    <= tag_s3_d;
            tag_s4_q    <= tag_s4_d;
            tag_s5_q    <= tag_s5_d;
            char_addr_q <= char_addr_d;
            font_addr_q <= font_addr_d;
            rgb_q       <= rgb_d;
            origin_q    <= origin_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign oCharAddr            = char_addr_q;
    assign oFontAddr            = font_addr_q;
    assign {oRed, oGreen, oBlue} = rgb_q;

endmodule
